alu_exec: RTL and testbench
===========================

// Module: alu_exec
// PURPOSE
//  Execute-stage ALU: the consumer of the 3-bit aluctrl code produced by the ALU decoder.
//  Accepts operands plus aluctrl over a valid/ready handshake and returns a registered result with zero/overflow flags.
//  Single-cycle ops take 1 cycle; ctrl 3'b011 is a W-cycle iterative unsigned multiply (low W bits), which stalls the handshake.
//  Sits between the ID/EX pipeline register and the EX/MEM register; in_ready feeds the pipeline stall logic.
// PARAMETERS
//  W  32  operand/result width (>=4)
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operands/aluctrl valid
//  in_ready   out  1  block can accept this cycle
//  aluctrl    in   3  000 and, 001 or, 010 add, 011 mulu, 100 xor, 101 nor, 110 sub, 111 slt
//  a          in   W  operand A (rs)
//  b          in   W  operand B (rt/imm)
//  out_valid  out  1  result valid
//  out_ready  in   1  downstream accepts result
//  result     out  W  registered result
//  zero       out  1  result == 0 (beq uses this with sub)
//  overflow   out  1  signed overflow for add/sub; 0 for every other op
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, zero=0, overflow=0, in_ready=0 during reset, 1 after.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  FSM: IDLE -> (accept, op!=011) IDLE with result loaded at next edge, out_valid=1 (latency 1).
//       IDLE -> (accept, op==011) MUL; latch a,b; acc=0; cnt=W-1.
//       MUL: each cycle if b[0] acc+=a; a<<=1; b>>=1; cnt--; when cnt==0 load result=acc(+final term), out_valid=1, -> IDLE.
//       Mul latency: out_valid rises exactly W cycles after accept edge; in_ready=0 throughout MUL.
//  Output hold: while out_valid & !out_ready, result/zero/overflow stable, in_ready=0.
//  out_valid & out_ready & new accept in same cycle: old result retired, new result replaces it next edge (back-to-back 1/cycle).
//  out_valid & out_ready with no accept: out_valid -> 0; result keeps last value.
//  Arithmetic: add/sub modulo 2^W; overflow = sign(a)==sign(b') & sign(res)!=sign(a), b'=b or ~b+1.
//  slt: result = {W-1 zeros, a<b signed}, correct even when a-b overflows; overflow=0.
//  mulu: low W bits of unsigned a*b; overflow=0; zero from final result.
//  zero and overflow registered with result, same cycle.
//  rst asserted mid-MUL: abort immediately, partial product discarded, out_valid=0, state=IDLE.
//  Inputs ignored when not accepted; aluctrl/a/b may change freely during MUL.
// STRUCTURE
//  Shared package alu_pkg: localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010,
//   ALU_MULU=3'b011, ALU_XOR=3'b100, ALU_NOR=3'b101, ALU_SUB=3'b110, ALU_SLT=3'b111;
//   state encodings S_IDLE/S_MUL; the decoder and this block both import it.
//  One sub-module: alu_mul_iter (start/busy/done, W-bit shift-add datapath, counter).
//  Combinational single-cycle datapath + output register + handshake FSM stay in alu_exec.
// TESTING
//  add 0x7FFFFFFF+1, out_ready=1 -> next cycle result=0x80000000, overflow=1, zero=0.
//  sub 5-5 -> result=0, zero=1, overflow=0; slt a=0x80000000,b=1 -> result=1, overflow=0.
//  mulu 0x0001_0003*0x0000_0005 -> in_ready=0 for W cycles, then result=0x0005_000F, out_valid=1.
//  out_ready=0 after add 2+3 -> result=5 held 4 cycles, in_ready=0; new in_valid not accepted until out_ready=1.
//  stream and/or/xor/nor with out_ready=1 every cycle -> one result per cycle, no bubbles, values match model.
//  assert rst at MUL cycle 10 -> out_valid=0 immediately; after release, add 1+1 returns 2 with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: aluctrl encodings, execute FSM states and
// a signed-overflow helper. Imported by the ALU decoder and alu_exec.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MULU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } alu_state_t;

  // Signed overflow of x + y = s, given only the three sign bits.
  // For subtraction pass the sign of the negated second operand.
  function automatic logic add_ovf(input logic sx, input logic sy, input logic ss);
    return (sx == sy) && (ss != sx);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// start latches the operands; done is high in the last busy cycle, when
// product already includes the final partial term.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W);

  logic [W-1:0]  acc;
  logic [W-1:0]  ma;
  logic [W-1:0]  mb;
  logic [CW-1:0] cnt;
  logic [W-1:0]  term;

  assign term    = mb[0] ? ma : '0;
  assign done    = busy && (cnt == '0);
  assign product = acc + term;

  // Operand latch on start, then one shift-add step per cycle until cnt hits 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      acc  <= '0;
      ma   <= '0;
      mb   <= '0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      acc  <= '0;
      ma   <= a;
      mb   <= b;
      cnt  <= CW'(W - 1);
    end else if (busy) begin
      if (cnt == '0) begin
        busy <= 1'b0;
      end else begin
        acc <= acc + term;
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU. Single-cycle ops return a result one edge after
// accept; mulu runs the iterative multiplier and blocks new input.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. in_valid/aluctrl/a/b are only sampled on an input transfer;
// result/zero/overflow are stable while out_valid is high and out_ready low.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   aluctrl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow
);

  alu_state_t   state;
  logic         accept;
  logic         mul_start;
  logic         mul_busy;
  logic         mul_done;
  logic [W-1:0] mul_product;

  logic [W-1:0] sum;
  logic [W-1:0] diff;
  logic         ovf_add;
  logic         ovf_sub;
  logic [W-1:0] alu_res;
  logic         alu_ovf;

  assign in_ready  = !rst && (state == S_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (aluctrl == ALU_MULU);

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = add_ovf(a[W-1], b[W-1], sum[W-1]);
  assign ovf_sub = add_ovf(a[W-1], !b[W-1], diff[W-1]);

  // Single-cycle datapath; slt corrects the sign of a-b when it overflows
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluctrl)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = ovf_add;
      end
      ALU_XOR: alu_res = a ^ b;
      ALU_NOR: alu_res = ~(a | b);
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = ovf_sub;
      end
      ALU_SLT: alu_res = {{(W-1){1'b0}}, diff[W-1] ^ ovf_sub};
      default: alu_res = '0;
    endcase
  end

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Handshake FSM and output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (aluctrl == ALU_MULU) begin
              state     <= S_MUL;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            result    <= mul_product;
            zero      <= (mul_product == '0);
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed corner cases plus randomized
// traffic, checked by a scoreboard against an arithmetic reference model.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   aluctrl = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit rand_done = 1'b0;

  logic [W+1:0] exp_q[$];

  alu_exec #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctrl   (aluctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: {result, zero, overflow} from plain signed/unsigned arithmetic
  function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint full;
    logic [63:0] prod;
    logic [W-1:0] r;
    logic ov;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    ov = 1'b0;
    case (op)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        full = sx + sy;
        r = full[W-1:0];
        ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      3'd3: begin
        prod = {32'd0, x} * {32'd0, y};
        r = prod[W-1:0];
      end
      3'd4: r = x ^ y;
      3'd5: r = ~(x | y);
      3'd6: begin
        full = sx - sy;
        r = full[W-1:0];
        ov = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      end
      default: r = (sx < sy) ? 1 : 0;
    endcase
    return {r, (r == '0), ov};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;
    corners[5] = 32'h8000_0001;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // driver: present one operation and hold it until accepted
  task automatic send(input logic [2:0] op, input logic [W-1:0] xa, input logic [W-1:0] xb, input bit push);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    aluctrl = op;
    a = xa;
    b = xb;
    @(negedge clk);
    while (!in_ready && waited < 300) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", {63'd0, in_ready}, 64'd1);
    else if (push) exp_q.push_back(model(op, xa, xb));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // monitor: compare every output transfer against the expected queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got 0x%0h expected nothing", result);
      end else begin
        check("scoreboard", {30'd0, result, zero, overflow}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : stim
    bit bad;
    int t0;
    int waited;
    logic [2:0] ops [4];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101;

    // reset values
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_flags", {62'd0, zero, overflow}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // add overflow, then latency-1 result
    send(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1);
    check("add_ovf_result", {32'd0, result}, 64'h8000_0000);
    check("add_ovf_flag", {62'd0, zero, overflow}, 64'd1);
    send(3'b110, 32'd5, 32'd5, 1'b1);
    send(3'b111, 32'h8000_0000, 32'd1, 1'b1);
    check("slt_result", {32'd0, result}, 64'd1);
    check("slt_ovf", {63'd0, overflow}, 64'd0);

    // multiply: stall for W cycles, then result
    send(3'b011, 32'h0001_0003, 32'h0000_0005, 1'b1);
    bad = 1'b0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (in_ready || out_valid) bad = 1'b1;
    end
    check("mul_stall", {63'd0, bad}, 64'd0);
    @(negedge clk);
    check("mul_valid", {63'd0, out_valid}, 64'd1);
    check("mul_result", {32'd0, result}, 64'h0005_000F);

    // output hold under back-pressure, pending input not accepted
    @(posedge clk);
    #1;
    send(3'b010, 32'd2, 32'd3, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    aluctrl = 3'b100;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!out_valid || result != 32'd5 || zero || overflow || in_ready) bad = 1'b1;
    end
    check("hold_stable", {63'd0, bad}, 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // logic stream with no bubbles
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(ops[i % 4], $urandom, $urandom, 1'b1);
    check("stream_cycles", 64'(cyc - t0), 64'd8);

    // reset in the middle of a multiply
    @(posedge clk);
    #1;
    send(3'b011, $urandom, $urandom, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mul_abort_valid", {63'd0, out_valid}, 64'd0);
    check("mul_abort_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(3'b010, 32'd1, 32'd1, 1'b1);
    check("post_abort_valid", {63'd0, out_valid}, 64'd1);
    check("post_abort_result", {32'd0, result}, 64'd2);

    // randomized traffic with random back-pressure
    fork
      begin
        for (int i = 0; i < 120; i++) send(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;

    // drain
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
